mem_stage: RTL and testbench

Memory-access stage of the five-stage in-order pipeline, sitting between the EX stage and the WB stage. Registers the instruction handed over by EX, takes the synchronous data-SRAM read word whose request EX issued one cycle earlier, and extracts and extends load data by type and byte offset. Presents the packed register-write bundle to WB and to ID for bypassing under the valid/allowin handshake.

---
 rtl/mem_stage.sv | 100 ++++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: registers EX payload, holds the SRAM read word
// across WB stalls, and aligns/extends load data for writeback.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_mem_valid,
  input  logic [31:0] ex_pc,
  input  logic [42:0] ex_mem_zip,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_allowin,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [37:0] mem_rf_zip
);

  logic        mem_ready_go;
  logic        accept;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic [31:0] pc_q;
  logic [4:0]  ld_op_q;
  logic        rf_we_q;
  logic [4:0]  waddr_q;
  logic [31:0] alu_q;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] rdata;
  logic [1:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] wdata;

  assign mem_ready_go    = 1'b1;
  assign mem_allowin     = ~valid_q | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = valid_q & mem_ready_go;
  assign accept          = ex_to_mem_valid & mem_allowin;

  assign valid_d = mem_allowin ? ex_to_mem_valid : valid_q;
  assign first_d = accept;
  // Snapshot the SRAM word only when the instruction is about to stall.
  assign rbuf_d  = (first_q & ~wb_allowin) ? data_sram_rdata : rbuf_q;

  // Handshake state and the read-word holding buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Payload loads only on an accepted instruction; bubbles keep it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= '0;
      ld_op_q <= '0;
      rf_we_q <= 1'b0;
      waddr_q <= '0;
      alu_q   <= '0;
    end else if (accept) begin
      pc_q    <= ex_pc;
      ld_op_q <= ex_mem_zip[42:38];
      rf_we_q <= ex_mem_zip[37];
      waddr_q <= ex_mem_zip[36:32];
      alu_q   <= ex_mem_zip[31:0];
    end
  end

  assign rdata = first_q ? data_sram_rdata : rbuf_q;
  assign off   = alu_q[1:0];

  // Pick the addressed byte/halfword and extend it by load type.
  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    wdata  = alu_q;
    case (1'b1)
      ld_op_q[0]: wdata = {{24{byte_v[7]}}, byte_v};
      ld_op_q[1]: wdata = {24'd0, byte_v};
      ld_op_q[2]: wdata = {{16{half_v[15]}}, half_v};
      ld_op_q[3]: wdata = {16'd0, half_v};
      ld_op_q[4]: wdata = rdata;
      default:    wdata = alu_q;
    endcase
  end

  assign mem_pc     = pc_q;
  assign mem_rf_zip = {rf_we_q & valid_q, waddr_q, wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for load extraction plus
// sequences for stall, bubble, reset and simultaneous handoff.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_to_mem_valid;
  logic [31:0] ex_pc;
  logic [42:0] ex_mem_zip;
  logic [31:0] data_sram_rdata;
  logic        mem_allowin;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [37:0] mem_rf_zip;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_pc           (ex_pc),
    .ex_mem_zip      (ex_mem_zip),
    .data_sram_rdata (data_sram_rdata),
    .mem_allowin     (mem_allowin),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_pc          (mem_pc),
    .mem_rf_zip      (mem_rf_zip)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [37:0] zip;
  } exp_t;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_B    = 5'b00001;
  localparam logic [4:0] OP_BU   = 5'b00010;
  localparam logic [4:0] OP_H    = 5'b00100;
  localparam logic [4:0] OP_HU   = 5'b01000;
  localparam logic [4:0] OP_W    = 5'b10000;

  exp_t sb[$];
  vec_t vt[16];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e.pc  = pc;
    e.zip = {we, wa, wd};
    sb.push_back(e);
  endtask

  task automatic sample(input string nm, input logic exp_v,
                        input logic exp_al);
    exp_t e;
    chk({nm, ".valid"}, {63'd0, mem_to_wb_valid}, {63'd0, exp_v});
    chk({nm, ".allowin"}, {63'd0, mem_allowin}, {63'd0, exp_al});
    if (!exp_v) begin
      chk({nm, ".we_gated"}, {63'd0, mem_rf_zip[37]}, 64'd0);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty with valid output", nm);
    end else begin
      e = sb[0];
      chk({nm, ".pc"}, {32'd0, mem_pc}, {32'd0, e.pc});
      chk({nm, ".zip"}, {26'd0, mem_rf_zip}, {26'd0, e.zip});
      if (wb_allowin) void'(sb.pop_front());
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    ex_to_mem_valid = 1'b1;
    ex_pc           = v.pc;
    ex_mem_zip      = {v.op, v.we, v.wa, v.alu};
    wb_allowin      = 1'b1;
    push(v.pc, v.we, v.wa, v.wd);
    @(posedge clk);
    #1;
    ex_to_mem_valid = 1'b0;
    data_sram_rdata = v.rd;
    #1;
    sample(v.nm, 1'b1, 1'b1);
  endtask

  task automatic bubble(input string nm);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    wb_allowin      = 1'b1;
    @(posedge clk);
    #2;
    sample(nm, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{"alu_pass", OP_NONE, 1'b1, 5'd5, 32'h1c000000,
               32'h12345678, 32'hAAAAAAAA, 32'h12345678};
    vt[1]  = '{"ld_b_o0", OP_B, 1'b1, 5'd1, 32'h1c000004,
               32'h00001000, 32'h80FF7F01, 32'h00000001};
    vt[2]  = '{"ld_b_o1", OP_B, 1'b1, 5'd2, 32'h1c000008,
               32'h00001001, 32'h80FF7F01, 32'h0000007F};
    vt[3]  = '{"ld_b_o2", OP_B, 1'b1, 5'd3, 32'h1c00000c,
               32'h00001002, 32'h80FF7F01, 32'hFFFFFFFF};
    vt[4]  = '{"ld_b_o3", OP_B, 1'b1, 5'd4, 32'h1c000010,
               32'h00001003, 32'h80FF7F01, 32'hFFFFFF80};
    vt[5]  = '{"ld_bu_o3", OP_BU, 1'b1, 5'd6, 32'h1c000014,
               32'h00001003, 32'h80FF7F01, 32'h00000080};
    vt[6]  = '{"ld_bu_o2", OP_BU, 1'b1, 5'd7, 32'h1c000018,
               32'h00001002, 32'h80FF7F01, 32'h000000FF};
    vt[7]  = '{"ld_h_o0", OP_H, 1'b1, 5'd8, 32'h1c00001c,
               32'h00002000, 32'h8001F00F, 32'hFFFFF00F};
    vt[8]  = '{"ld_hu_o2", OP_HU, 1'b1, 5'd9, 32'h1c000020,
               32'h00002002, 32'h8001F00F, 32'h00008001};
    vt[9]  = '{"ld_w", OP_W, 1'b1, 5'd10, 32'h1c000024,
               32'h00002000, 32'h8001F00F, 32'h8001F00F};
    vt[10] = '{"ld_hu_o0", OP_HU, 1'b1, 5'd11, 32'h1c000028,
               32'h00002000, 32'h8001F00F, 32'h0000F00F};
    vt[11] = '{"ld_h_o2", OP_H, 1'b1, 5'd12, 32'h1c00002c,
               32'h00002002, 32'h8001F00F, 32'hFFFF8001};
    vt[12] = '{"ld_h_o3", OP_H, 1'b1, 5'd13, 32'h1c000030,
               32'h00002003, 32'h8001F00F, 32'hFFFF8001};
    vt[13] = '{"ld_w_o1", OP_W, 1'b1, 5'd14, 32'h1c000034,
               32'h00002001, 32'h13579BDF, 32'h13579BDF};
    vt[14] = '{"no_we", OP_NONE, 1'b0, 5'd15, 32'h1c000038,
               32'hFEDCBA98, 32'h0, 32'hFEDCBA98};
    vt[15] = '{"ld_bu_o1", OP_BU, 1'b1, 5'd31, 32'h1c00003c,
               32'h00003001, 32'h80FF7F01, 32'h0000007F};

    resetn          = 1'b1;
    ex_to_mem_valid = 1'b0;
    ex_pc           = '0;
    ex_mem_zip      = '0;
    data_sram_rdata = '0;
    wb_allowin      = 1'b1;
    #1;
    resetn = 1'b0;
    #2;
    chk("rst.allowin", {63'd0, mem_allowin}, 64'd1);
    chk("rst.valid", {63'd0, mem_to_wb_valid}, 64'd0);
    chk("rst.pc", {32'd0, mem_pc}, 64'd0);
    chk("rst.zip", {26'd0, mem_rf_zip}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vt[i]);

    // WB stall: word captured in first cycle must survive rdata change
    @(negedge clk);
    ex_to_mem_valid = 1'b1;
    ex_pc           = 32'h1c000100;
    ex_mem_zip      = {OP_W, 1'b1, 5'd9, 32'h00002000};
    wb_allowin      = 1'b1;
    push(32'h1c000100, 1'b1, 5'd9, 32'h11223344);
    @(posedge clk);
    #1;
    ex_to_mem_valid = 1'b1;
    ex_pc           = 32'h1c000104;
    ex_mem_zip      = {OP_NONE, 1'b1, 5'd10, 32'hCAFE0001};
    wb_allowin      = 1'b0;
    data_sram_rdata = 32'h11223344;
    #1;
    sample("stall_c0", 1'b1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk);
      #1;
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      sample("stall_hold", 1'b1, 1'b0);
    end
    @(negedge clk);
    wb_allowin = 1'b1;
    #1;
    sample("stall_release", 1'b1, 1'b1);
    push(32'h1c000104, 1'b1, 5'd10, 32'hCAFE0001);
    @(posedge clk);
    #1;
    ex_to_mem_valid = 1'b0;
    #1;
    sample("handoff_new", 1'b1, 1'b1);

    // Back-to-back with a bubble in between
    run_vec(vt[1]);
    bubble("bubble");
    run_vec(vt[9]);
    run_vec(vt[0]);
    run_vec(vt[5]);
    run_vec(vt[8]);

    // Asynchronous reset in mid-cycle with an instruction held
    #1;
    resetn = 1'b0;
    #1;
    chk("arst.valid", {63'd0, mem_to_wb_valid}, 64'd0);
    chk("arst.zip", {26'd0, mem_rf_zip}, 64'd0);
    chk("arst.pc", {32'd0, mem_pc}, 64'd0);
    chk("arst.allowin", {63'd0, mem_allowin}, 64'd1);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    run_vec(vt[3]);
    bubble("post_rst_bubble");

    chk("sb.drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
